instr_fetcher: RTL

INSTR_FETCHER -- requirements
Module: instr_fetcher

---
 rtl/instr_fetcher_pkg.sv | 19 +
 rtl/instr_fetcher_icache.sv | 56 +++++
 rtl/instr_fetcher.sv | 104 ++++++++++
 3 files changed

// File: rtl/instr_fetcher_pkg.sv
// Shared GPU encodings: core scheduler phases and instruction fetcher states.
package instr_fetcher_pkg;

    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_e;

endpackage

// File: rtl/instr_fetcher_icache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill and flush.
module icache_dm #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned LINES     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] lookup_addr,
    output logic                 hit_c,
    output logic [DATA_BITS-1:0] hit_data_c,
    input  logic                 fill_en,
    input  logic [ADDR_BITS-1:0] fill_addr,
    input  logic [DATA_BITS-1:0] fill_data
);

    localparam int unsigned IDX_BITS = $clog2(LINES);
    localparam int unsigned TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0] fill_tag;

    assign lookup_idx = lookup_addr[IDX_BITS-1:0];
    assign lookup_tag = lookup_addr[ADDR_BITS-1:IDX_BITS];
    assign fill_idx   = fill_addr[IDX_BITS-1:0];
    assign fill_tag   = fill_addr[ADDR_BITS-1:IDX_BITS];

    assign hit_c      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign hit_data_c = data_q[lookup_idx];

    // Flush beats a coincident fill, so the freshly written line stays invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetcher: serves core FETCH phases from the icache or program memory.
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned CACHE_LINES           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    fetcher_state_e                   state_q, state_d;
    logic                             valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
    logic                             fill_en;
    logic                             hit_c;
    logic [PROGRAM_MEM_DATA_BITS-1:0] hit_data_c;

    icache_dm #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .LINES     (CACHE_LINES)
    ) u_icache (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .lookup_addr (current_pc),
        .hit_c       (hit_c),
        .hit_data_c  (hit_data_c),
        .fill_en     (fill_en),
        .fill_addr   (addr_q),
        .fill_data   (mem_read_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCHER_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    // Next state and next registered outputs; ready outside FETCHING is ignored.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        fill_en = 1'b0;
        case (state_q)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (hit_c) begin
                        state_d = FETCHER_FETCHED;
                        instr_d = hit_data_c;
                    end else begin
                        state_d = FETCHER_FETCHING;
                        valid_d = 1'b1;
                        addr_d  = current_pc;
                    end
                end
            end
            FETCHER_FETCHING: begin
                if (mem_read_ready) begin
                    state_d = FETCHER_FETCHED;
                    instr_d = mem_read_data;
                    valid_d = 1'b0;
                    fill_en = 1'b1;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = FETCHER_IDLE;
                end
            end
            default: begin
                state_d = FETCHER_IDLE;
            end
        endcase
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;

endmodule
